big_core_vga_char_writer: RTL and testbench
===========================================

// Module: big_core_vga_char_writer
// PURPOSE
//  Text-mode writer into the VGA frame memory: accepts 8-bit character codes, fetches 8x8 glyphs from a font ROM
//  and writes them as two 32-bit words on the VGA memory write port. Maintains a text cursor (80x60 cells).
//  Word layout: byte k holds pixel line 4*g+k, bit b holds x=8*c+b, word index = g*COLS + c.
//  So cell (col,row) = word (2*row)*COLS+col (glyph lines 0-3) + word (2*row+1)*COLS+col (glyph lines 4-7).
// PARAMETERS
//  VGA_MEM_BASE  32'h0000_0000  byte address of frame memory word 0
//  COLS          80             text columns (<=128)
//  ROWS          60             text rows (<=64)
// PORTS
//  Clk             in   1   clock
//  Reset           in   1   synchronous, active-high reset
//  CharValid       in   1   CharCode valid
//  CharReady       out  1   block accepts CharCode (transfer = CharValid & CharReady)
//  CharCode        in   8   character code
//  CursorSetValid  in   1   one-cycle pulse: load cursor
//  CursorSetCol    in   7   new column
//  CursorSetRow    in   6   new row
//  FontAddr        out  9   {CharCode, half}; half 0 = glyph lines 0-3, 1 = lines 4-7
//  FontData        in   32  glyph word, valid 1 cycle after FontAddr; byte k = line 4*half+k, bit b = x offset b
//  VgaWrData       out  32  write data
//  VgaWrAddress    out  32  byte address = VGA_MEM_BASE + 4*word index
//  VgaWrByteEn     out  4   always 4'hF while VgaWrEn
//  VgaWrEn         out  1   write request, held until VgaWrReady
//  VgaWrReady      in   1   write accepted this cycle (VgaWrEn & VgaWrReady)
//  Busy            out  1   state != IDLE
//  CursorCol       out  7   current column
//  CursorRow       out  6   current row
// BEHAVIOUR
//  Reset: state IDLE, cursor (0,0), VgaWrEn=0, VgaWrData/Address/ByteEn=0, FontAddr=0, CharReady=0 in reset cycle.
//  Reset mid-operation aborts at once: no further writes (top word may already be written), cursor -> (0,0).
//  CharReady = (state==IDLE) & !CursorSetValid & !Reset.
//  CursorSetValid in IDLE loads cursor (field >= COLS/ROWS loads 0); ignored while Busy. Priority over CharValid.
//  FSM: IDLE -> FETCH0 -> WAIT0 -> WR0 -> FETCH1 -> WAIT1 -> WR1 -> IDLE.
//   IDLE: on accept of printable code, latch code and cursor; go FETCH0.
//   FETCH0/FETCH1: drive FontAddr={code,0}/{code,1}.
//   WAIT0/WAIT1: capture FontData into data register; compute word address.
//   WR0/WR1: VgaWrEn=1; Data/Address/ByteEn registered and stable until VgaWrReady.
//   On VgaWrReady, advance to FETCH1 / IDLE.
//   WR1 exit edge advances cursor.
//  Min latency: accept at cycle T -> WR0 at T+3, WR1 at T+6, CharReady high again at T+7.
//  Control codes (no memory access, handled on accept edge, CharReady stays high next cycle):
//   8'h0A newline -> col=0, row+1.
//   8'h0D CR -> col=0.
//  Cursor advance: col+1; at col==COLS-1 -> col=0,row+1; row+1 at ROWS-1 wraps to 0 (no scrolling).
//  Address math: word index 14 bit = (2*row+half)*COLS+col, no truncation for COLS<=128,ROWS<=64; byte addr 32 bit.
//  All codes other than 0x0A/0x0D are written (font ROM owns glyph content, incl. 0x20 blank).
// TESTING
//  1 Reset, CharCode 8'h41 at (0,0), VgaWrReady=1.
//    -> FontAddr 9'h082 then 9'h083; writes BASE+0 then BASE+320, ByteEn F, data=FontData.
//    -> cursor (1,0); CharReady high at T+7.
//  2 Char at (0,0), VgaWrReady low 5 cycles in WR0.
//    -> VgaWrEn/Address/Data stable all 5 cycles; exactly one write per word; FETCH1 only after accept.
//  3 CursorSet (79,59), CharCode 8'h20.
//    -> writes BASE+38076 (word 9519) and BASE+38396 (word 9599); cursor wraps to (0,0).
//  4 Cursor (10,5), CharCode 8'h0A -> no VgaWrEn; cursor (0,6); CharReady high next cycle.
//    CharCode 8'h0D at (10,5) -> (0,5).
//  5 CursorSetValid (3,2) and CharValid same IDLE cycle -> cursor (3,2), CharReady=0.
//    Char accepted next cycle, writes words 323 and 403 (BASE+1292, BASE+1612).
//  6 Reset asserted during WAIT1.
//    -> next cycle IDLE, VgaWrEn=0, cursor (0,0), no WR1 write; new char afterwards behaves as test 1.

Source files
------------

// File: rtl/big_core_vga_char_writer.sv
// Text-mode character writer: fetches 8x8 glyphs from a font ROM and writes them as two words into VGA memory.
// Latency: accept T -> WR0 at T+3, WR1 at T+6, ready at T+7; holds write request until VgaWrReady, CharReady low while busy.
module big_core_vga_char_writer #(
    parameter logic [31:0] VGA_MEM_BASE = 32'h0000_0000,
    parameter int          COLS         = 80,
    parameter int          ROWS         = 60
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        CharValid,
    output logic        CharReady,
    input  logic [7:0]  CharCode,
    input  logic        CursorSetValid,
    input  logic [6:0]  CursorSetCol,
    input  logic [5:0]  CursorSetRow,
    output logic [8:0]  FontAddr,
    input  logic [31:0] FontData,
    output logic [31:0] VgaWrData,
    output logic [31:0] VgaWrAddress,
    output logic [3:0]  VgaWrByteEn,
    output logic        VgaWrEn,
    input  logic        VgaWrReady,
    output logic        Busy,
    output logic [6:0]  CursorCol,
    output logic [5:0]  CursorRow
);

    typedef enum logic [2:0] {IDLE, FETCH0, WAIT0, WR0, FETCH1, WAIT1, WR1} state_t;

    localparam logic [6:0]  LAST_COL = 7'(COLS - 1);
    localparam logic [5:0]  LAST_ROW = 6'(ROWS - 1);
    localparam logic [7:0]  COLS_8   = 8'(COLS);
    localparam logic [6:0]  ROWS_7   = 7'(ROWS);
    localparam logic [13:0] COLS_14  = 14'(COLS);

    state_t      state, next_state;
    logic [7:0]  code_q;
    logic [6:0]  col_q;
    logic [5:0]  row_q;
    logic        accept;
    logic        is_ctrl;
    logic        half;
    logic [13:0] word_idx;
    logic [5:0]  row_inc;

    assign accept  = CharValid & CharReady;
    assign is_ctrl = (CharCode == 8'h0A) || (CharCode == 8'h0D);
    assign row_inc = (CursorRow == LAST_ROW) ? 6'd0 : CursorRow + 6'd1;

    // Glyph line group g = 2*row + half selects the band of words for this cell.
    assign half     = (state == WAIT1);
    assign word_idx = {7'd0, row_q, half} * COLS_14 + {7'd0, col_q};

    always_ff @(posedge Clk) begin
        if (Reset) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (accept && !is_ctrl) next_state = FETCH0;
            FETCH0:  next_state = WAIT0;
            WAIT0:   next_state = WR0;
            WR0:     if (VgaWrReady) next_state = FETCH1;
            FETCH1:  next_state = WAIT1;
            WAIT1:   next_state = WR1;
            WR1:     if (VgaWrReady) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        CharReady = (state == IDLE) && !CursorSetValid && !Reset;
        Busy      = (state != IDLE);
        VgaWrEn   = ((state == WR0) || (state == WR1)) && !Reset;
        FontAddr  = 9'd0;
        if (!Reset) begin
            if (state == FETCH0)      FontAddr = {code_q, 1'b0};
            else if (state == FETCH1) FontAddr = {code_q, 1'b1};
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            CursorCol    <= 7'd0;
            CursorRow    <= 6'd0;
            code_q       <= 8'd0;
            col_q        <= 7'd0;
            row_q        <= 6'd0;
            VgaWrData    <= 32'd0;
            VgaWrAddress <= 32'd0;
            VgaWrByteEn  <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (CursorSetValid) begin
                        CursorCol <= ({1'b0, CursorSetCol} >= COLS_8) ? 7'd0 : CursorSetCol;
                        CursorRow <= ({1'b0, CursorSetRow} >= ROWS_7) ? 6'd0 : CursorSetRow;
                    end else if (accept) begin
                        if (CharCode == 8'h0A) begin
                            CursorCol <= 7'd0;
                            CursorRow <= row_inc;
                        end else if (CharCode == 8'h0D) begin
                            CursorCol <= 7'd0;
                        end else begin
                            code_q <= CharCode;
                            col_q  <= CursorCol;
                            row_q  <= CursorRow;
                        end
                    end
                end
                WAIT0, WAIT1: begin
                    VgaWrData    <= FontData;
                    VgaWrAddress <= VGA_MEM_BASE + {16'd0, word_idx, 2'b00};
                    VgaWrByteEn  <= 4'hF;
                end
                WR1: begin
                    if (VgaWrReady) begin
                        if (CursorCol == LAST_COL) begin
                            CursorCol <= 7'd0;
                            CursorRow <= row_inc;
                        end else begin
                            CursorCol <= CursorCol + 7'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_big_core_vga_char_writer.sv
// Directed bench for big_core_vga_char_writer with a registered font ROM model and a write/fetch log.
module tb_big_core_vga_char_writer;

    localparam logic [31:0] BASE = 32'h0010_0000;

    logic        Clk;
    logic        Reset;
    logic        CharValid;
    logic        CharReady;
    logic [7:0]  CharCode;
    logic        CursorSetValid;
    logic [6:0]  CursorSetCol;
    logic [5:0]  CursorSetRow;
    logic [8:0]  FontAddr;
    logic [31:0] FontData;
    logic [31:0] VgaWrData;
    logic [31:0] VgaWrAddress;
    logic [3:0]  VgaWrByteEn;
    logic        VgaWrEn;
    logic        VgaWrReady;
    logic        Busy;
    logic [6:0]  CursorCol;
    logic [5:0]  CursorRow;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    logic [31:0] wr_addr_q[$];
    logic [31:0] wr_data_q[$];
    logic [3:0]  wr_be_q[$];
    int          wr_cyc_q[$];
    logic [8:0]  fa_q[$];
    int          fa_cyc_q[$];

    big_core_vga_char_writer #(.VGA_MEM_BASE(BASE), .COLS(80), .ROWS(60)) dut (
        .Clk(Clk), .Reset(Reset), .CharValid(CharValid), .CharReady(CharReady), .CharCode(CharCode),
        .CursorSetValid(CursorSetValid), .CursorSetCol(CursorSetCol), .CursorSetRow(CursorSetRow),
        .FontAddr(FontAddr), .FontData(FontData), .VgaWrData(VgaWrData), .VgaWrAddress(VgaWrAddress),
        .VgaWrByteEn(VgaWrByteEn), .VgaWrEn(VgaWrEn), .VgaWrReady(VgaWrReady), .Busy(Busy),
        .CursorCol(CursorCol), .CursorRow(CursorRow)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    function automatic logic [31:0] fw(input logic [8:0] a);
        return {a, ~a[7:0], a[7:0], 7'h2B};
    endfunction

    always @(posedge Clk) begin
        cyc      <= cyc + 1;
        FontData <= fw(FontAddr);
    end

    always @(negedge Clk) begin
        if (VgaWrEn && VgaWrReady) begin
            wr_addr_q.push_back(VgaWrAddress);
            wr_data_q.push_back(VgaWrData);
            wr_be_q.push_back(VgaWrByteEn);
            wr_cyc_q.push_back(cyc);
        end
        if (FontAddr != 9'd0) begin
            fa_q.push_back(FontAddr);
            fa_cyc_q.push_back(cyc);
        end
    end

    task automatic clear_logs();
        wr_addr_q.delete(); wr_data_q.delete(); wr_be_q.delete(); wr_cyc_q.delete();
        fa_q.delete(); fa_cyc_q.delete();
    endtask

    task automatic send_char(input logic [7:0] code, output int acc);
        acc = -1;
        CharValid = 1'b1;
        CharCode  = code;
        for (int i = 0; i < 30; i++) begin
            @(negedge Clk);
            if (CharReady) begin
                acc = cyc;
                break;
            end
        end
        @(posedge Clk); #1;
        CharValid = 1'b0;
        vectors++;
        if (acc < 0) begin miscompares++; $display("FAIL accept_timeout: code %h never accepted", code); end
    endtask

    task automatic wait_idle(output int c);
        c = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge Clk);
            if (!Busy && CharReady) begin
                c = cyc;
                break;
            end
        end
        @(posedge Clk); #1;
        vectors++;
        if (c < 0) begin miscompares++; $display("FAIL idle_timeout: block stayed busy"); end
    endtask

    task automatic cursor_set(input logic [6:0] col, input logic [5:0] row);
        CursorSetValid = 1'b1;
        CursorSetCol   = col;
        CursorSetRow   = row;
        @(posedge Clk); #1;
        CursorSetValid = 1'b0;
    endtask

    task automatic test_reset();
        Reset = 1'b1; CharValid = 1'b0; CharCode = 8'd0; CursorSetValid = 1'b0;
        CursorSetCol = 7'd0; CursorSetRow = 6'd0; VgaWrReady = 1'b1;
        repeat (2) @(posedge Clk);
        #1;
        @(negedge Clk);
        vectors++; if (CharReady !== 1'b0) begin miscompares++; $display("FAIL rst_charready: got %b want 0", CharReady); end
        vectors++; if (VgaWrEn !== 1'b0) begin miscompares++; $display("FAIL rst_wren: got %b want 0", VgaWrEn); end
        vectors++; if (FontAddr !== 9'd0) begin miscompares++; $display("FAIL rst_fontaddr: got %h want 0", FontAddr); end
        vectors++; if ({VgaWrData, VgaWrAddress, VgaWrByteEn} !== 68'd0) begin
            miscompares++; $display("FAIL rst_wrregs: got %h %h %h want 0", VgaWrData, VgaWrAddress, VgaWrByteEn); end
        @(posedge Clk); #1;
        Reset = 1'b0;
        @(negedge Clk);
        vectors++; if (CharReady !== 1'b1) begin miscompares++; $display("FAIL post_rst_ready: got %b want 1", CharReady); end
        vectors++; if ({CursorCol, CursorRow, Busy} !== 14'd0) begin
            miscompares++; $display("FAIL post_rst_cursor: got (%0d,%0d) busy %b want (0,0) 0", CursorCol, CursorRow, Busy); end
        @(posedge Clk); #1;
    endtask

    task automatic test_basic_char();
        int t, ti;
        clear_logs();
        VgaWrReady = 1'b1;
        send_char(8'h41, t);
        wait_idle(ti);
        vectors++; if (ti !== t + 7) begin miscompares++; $display("FAIL t1_ready_again: got T+%0d want T+7", ti - t); end
        vectors++; if (wr_addr_q.size() !== 2) begin miscompares++; $display("FAIL t1_write_count: got %0d want 2", wr_addr_q.size()); end
        vectors++; if (fa_q.size() !== 2) begin miscompares++; $display("FAIL t1_fetch_count: got %0d want 2", fa_q.size()); end
        if (wr_addr_q.size() == 2 && fa_q.size() == 2) begin
            vectors++; if (wr_addr_q[0] !== BASE) begin miscompares++; $display("FAIL t1_addr0: got %h want %h", wr_addr_q[0], BASE); end
            vectors++; if (wr_addr_q[1] !== BASE + 32'd320) begin miscompares++; $display("FAIL t1_addr1: got %h want %h", wr_addr_q[1], BASE + 32'd320); end
            vectors++; if (wr_data_q[0] !== fw(9'h082)) begin miscompares++; $display("FAIL t1_data0: got %h want %h", wr_data_q[0], fw(9'h082)); end
            vectors++; if (wr_data_q[1] !== fw(9'h083)) begin miscompares++; $display("FAIL t1_data1: got %h want %h", wr_data_q[1], fw(9'h083)); end
            vectors++; if ({wr_be_q[0], wr_be_q[1]} !== 8'hFF) begin miscompares++; $display("FAIL t1_byteen: got %h %h want F F", wr_be_q[0], wr_be_q[1]); end
            vectors++; if (wr_cyc_q[0] !== t + 3 || wr_cyc_q[1] !== t + 6) begin
                miscompares++; $display("FAIL t1_wr_timing: got T+%0d T+%0d want T+3 T+6", wr_cyc_q[0] - t, wr_cyc_q[1] - t); end
            vectors++; if (fa_q[0] !== 9'h082 || fa_q[1] !== 9'h083) begin
                miscompares++; $display("FAIL t1_fontaddr: got %h %h want 082 083", fa_q[0], fa_q[1]); end
            vectors++; if (fa_cyc_q[0] !== t + 1 || fa_cyc_q[1] !== t + 4) begin
                miscompares++; $display("FAIL t1_fetch_timing: got T+%0d T+%0d want T+1 T+4", fa_cyc_q[0] - t, fa_cyc_q[1] - t); end
        end
        vectors++; if (CursorCol !== 7'd1 || CursorRow !== 6'd0) begin
            miscompares++; $display("FAIL t1_cursor: got (%0d,%0d) want (1,0)", CursorCol, CursorRow); end
    endtask

    task automatic test_backpressure();
        int t, ti;
        logic found;
        cursor_set(7'd0, 6'd0);
        clear_logs();
        VgaWrReady = 1'b0;
        send_char(8'h42, t);
        found = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge Clk);
            if (VgaWrEn) begin found = 1'b1; break; end
        end
        vectors++; if (!found) begin miscompares++; $display("FAIL t2_wr0_seen: got none want VgaWrEn"); end
        for (int i = 0; i < 5; i++) begin
            vectors++; if (VgaWrEn !== 1'b1 || VgaWrAddress !== BASE || VgaWrData !== fw({8'h42, 1'b0}) || FontAddr !== 9'd0) begin
                miscompares++; $display("FAIL t2_stall_cycle%0d: got en %b addr %h data %h fa %h want 1 %h %h 000",
                    i, VgaWrEn, VgaWrAddress, VgaWrData, FontAddr, BASE, fw({8'h42, 1'b0})); end
            if (i < 4) @(negedge Clk);
        end
        @(posedge Clk); #1;
        VgaWrReady = 1'b1;
        wait_idle(ti);
        vectors++; if (wr_addr_q.size() !== 2) begin miscompares++; $display("FAIL t2_write_count: got %0d want 2", wr_addr_q.size()); end
        if (wr_addr_q.size() == 2 && fa_q.size() == 2) begin
            vectors++; if (wr_addr_q[1] !== BASE + 32'd320) begin miscompares++; $display("FAIL t2_addr1: got %h want %h", wr_addr_q[1], BASE + 32'd320); end
            vectors++; if (fa_cyc_q[1] !== wr_cyc_q[0] + 1) begin
                miscompares++; $display("FAIL t2_fetch1_after_accept: got cycle %0d want %0d", fa_cyc_q[1], wr_cyc_q[0] + 1); end
        end
    endtask

    task automatic test_last_cell_wrap();
        int t, ti;
        cursor_set(7'd79, 6'd59);
        clear_logs();
        send_char(8'h20, t);
        wait_idle(ti);
        vectors++; if (wr_addr_q.size() !== 2) begin miscompares++; $display("FAIL t3_write_count: got %0d want 2", wr_addr_q.size()); end
        if (wr_addr_q.size() == 2) begin
            vectors++; if (wr_addr_q[0] !== BASE + 32'd38076) begin miscompares++; $display("FAIL t3_addr0: got %h want %h", wr_addr_q[0], BASE + 32'd38076); end
            vectors++; if (wr_addr_q[1] !== BASE + 32'd38396) begin miscompares++; $display("FAIL t3_addr1: got %h want %h", wr_addr_q[1], BASE + 32'd38396); end
        end
        vectors++; if (CursorCol !== 7'd0 || CursorRow !== 6'd0) begin
            miscompares++; $display("FAIL t3_cursor_wrap: got (%0d,%0d) want (0,0)", CursorCol, CursorRow); end
    endtask

    task automatic test_control_codes();
        int t;
        cursor_set(7'd10, 6'd5);
        clear_logs();
        send_char(8'h0A, t);
        @(negedge Clk);
        vectors++; if (CharReady !== 1'b1 || Busy !== 1'b0) begin
            miscompares++; $display("FAIL t4_nl_ready: got ready %b busy %b want 1 0", CharReady, Busy); end
        vectors++; if (CursorCol !== 7'd0 || CursorRow !== 6'd6) begin
            miscompares++; $display("FAIL t4_nl_cursor: got (%0d,%0d) want (0,6)", CursorCol, CursorRow); end
        @(posedge Clk); #1;
        cursor_set(7'd10, 6'd5);
        send_char(8'h0D, t);
        @(negedge Clk);
        vectors++; if (CursorCol !== 7'd0 || CursorRow !== 6'd5) begin
            miscompares++; $display("FAIL t4_cr_cursor: got (%0d,%0d) want (0,5)", CursorCol, CursorRow); end
        vectors++; if (wr_addr_q.size() !== 0 || fa_q.size() !== 0) begin
            miscompares++; $display("FAIL t4_no_mem_access: got %0d writes %0d fetches want 0 0", wr_addr_q.size(), fa_q.size()); end
        @(posedge Clk); #1;
    endtask

    task automatic test_set_priority();
        int t, ti;
        clear_logs();
        CursorSetValid = 1'b1; CursorSetCol = 7'd3; CursorSetRow = 6'd2;
        CharValid = 1'b1; CharCode = 8'h43;
        @(negedge Clk);
        vectors++; if (CharReady !== 1'b0) begin miscompares++; $display("FAIL t5_ready_during_set: got %b want 0", CharReady); end
        @(posedge Clk); #1;
        CursorSetValid = 1'b0;
        vectors++; if (CursorCol !== 7'd3 || CursorRow !== 6'd2) begin
            miscompares++; $display("FAIL t5_cursor_loaded: got (%0d,%0d) want (3,2)", CursorCol, CursorRow); end
        send_char(8'h43, t);
        wait_idle(ti);
        vectors++; if (wr_addr_q.size() !== 2) begin miscompares++; $display("FAIL t5_write_count: got %0d want 2", wr_addr_q.size()); end
        if (wr_addr_q.size() == 2) begin
            vectors++; if (wr_addr_q[0] !== BASE + 32'd1292 || wr_addr_q[1] !== BASE + 32'd1612) begin
                miscompares++; $display("FAIL t5_addrs: got %h %h want %h %h", wr_addr_q[0], wr_addr_q[1], BASE + 32'd1292, BASE + 32'd1612); end
        end
        vectors++; if (CursorCol !== 7'd4 || CursorRow !== 6'd2) begin
            miscompares++; $display("FAIL t5_cursor_after: got (%0d,%0d) want (4,2)", CursorCol, CursorRow); end
    endtask

    task automatic test_reset_mid_op();
        int t, ti;
        cursor_set(7'd7, 6'd3);
        clear_logs();
        VgaWrReady = 1'b1;
        send_char(8'h44, t);
        repeat (4) begin @(posedge Clk); #1; end
        Reset = 1'b1;
        @(negedge Clk);
        vectors++; if (VgaWrEn !== 1'b0) begin miscompares++; $display("FAIL t6_wren_in_reset: got %b want 0", VgaWrEn); end
        @(posedge Clk); #1;
        Reset = 1'b0;
        @(negedge Clk);
        vectors++; if (Busy !== 1'b0 || VgaWrEn !== 1'b0 || CharReady !== 1'b1) begin
            miscompares++; $display("FAIL t6_after_reset: got busy %b en %b ready %b want 0 0 1", Busy, VgaWrEn, CharReady); end
        vectors++; if (CursorCol !== 7'd0 || CursorRow !== 6'd0) begin
            miscompares++; $display("FAIL t6_cursor_reset: got (%0d,%0d) want (0,0)", CursorCol, CursorRow); end
        repeat (4) @(negedge Clk);
        vectors++; if (wr_addr_q.size() !== 1) begin miscompares++; $display("FAIL t6_write_count: got %0d want 1", wr_addr_q.size()); end
        if (wr_addr_q.size() == 1) begin
            vectors++; if (wr_addr_q[0] !== BASE + 32'd1948) begin miscompares++; $display("FAIL t6_top_addr: got %h want %h", wr_addr_q[0], BASE + 32'd1948); end
        end
        @(posedge Clk); #1;
        clear_logs();
        send_char(8'h41, t);
        wait_idle(ti);
        vectors++; if (ti !== t + 7 || wr_addr_q.size() !== 2) begin
            miscompares++; $display("FAIL t6_recover: got ready T+%0d with %0d writes want T+7 2", ti - t, wr_addr_q.size()); end
        if (wr_addr_q.size() == 2) begin
            vectors++; if (wr_addr_q[0] !== BASE || wr_addr_q[1] !== BASE + 32'd320 || wr_data_q[1] !== fw(9'h083)) begin
                miscompares++; $display("FAIL t6_recover_writes: got %h %h %h want %h %h %h",
                    wr_addr_q[0], wr_addr_q[1], wr_data_q[1], BASE, BASE + 32'd320, fw(9'h083)); end
        end
        vectors++; if (CursorCol !== 7'd1 || CursorRow !== 6'd0) begin
            miscompares++; $display("FAIL t6_recover_cursor: got (%0d,%0d) want (1,0)", CursorCol, CursorRow); end
    endtask

    initial begin
        test_reset();
        test_basic_char();
        test_backpressure();
        test_last_cell_wrap();
        test_control_codes();
        test_set_priority();
        test_reset_mid_op();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
